// File: rtl/rv32_pkg.sv
// Shared constants for the RV32I execute-slice: FS codes, flag positions, sizes.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  // FS = {funct3, funct7[5]}; the odd code of each pair aliases the even one
  // except for SUB (0001) and SRA (1011).
  localparam logic [3:0] FS_ADD  = 4'b0000;
  localparam logic [3:0] FS_SUB  = 4'b0001;
  localparam logic [3:0] FS_SLL  = 4'b0010;
  localparam logic [3:0] FS_SLT  = 4'b0100;
  localparam logic [3:0] FS_SLTU = 4'b0110;
  localparam logic [3:0] FS_XOR  = 4'b1000;
  localparam logic [3:0] FS_SRL  = 4'b1010;
  localparam logic [3:0] FS_SRA  = 4'b1011;
  localparam logic [3:0] FS_OR   = 4'b1100;
  localparam logic [3:0] FS_AND  = 4'b1110;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/FunctionUnit.sv
// Combinational RV32I ALU: result plus ZCNV flags (C/V only for ADD/SUB).
module FunctionUnit
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      FS,
  output logic [XLEN-1:0] S,
  output logic [3:0]      ZCNVFlags
);

  logic            is_sub;
  logic [XLEN-1:0] b_op;
  logic [XLEN:0]   sum;
  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic            c_flag;
  logic            v_flag;

  assign is_sub = (FS == FS_SUB);
  assign shamt  = B[4:0];
  assign lt_s   = $signed(A) < $signed(B);
  assign lt_u   = A < B;

  // shared adder: SUB is A + ~B + 1, so carry out means "no borrow"
  always_comb begin
    b_op = is_sub ? ~B : B;
    sum  = {1'b0, A} + {1'b0, b_op} + {{XLEN{1'b0}}, is_sub};
  end

  // result select
  always_comb begin
    S = '0;
    case (FS)
      FS_ADD, FS_SUB:                 S = sum[XLEN-1:0];
      FS_SLL, FS_SLL | 4'b0001:       S = A << shamt;
      FS_SLT, FS_SLT | 4'b0001:       S = {{(XLEN-1){1'b0}}, lt_s};
      FS_SLTU, FS_SLTU | 4'b0001:     S = {{(XLEN-1){1'b0}}, lt_u};
      FS_XOR, FS_XOR | 4'b0001:       S = A ^ B;
      FS_SRL:                         S = A >> shamt;
      FS_SRA:                         S = $unsigned($signed(A) >>> shamt);
      FS_OR, FS_OR | 4'b0001:         S = A | B;
      FS_AND, FS_AND | 4'b0001:       S = A & B;
      default:                        S = '0;
    endcase
  end

  // flags: overflow when both adder inputs agree in sign and the result does not
  always_comb begin
    c_flag = 1'b0;
    v_flag = 1'b0;
    if (FS == FS_ADD || is_sub) begin
      c_flag = sum[XLEN];
      v_flag = (A[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != A[XLEN-1]);
    end
    ZCNVFlags         = '0;
    ZCNVFlags[FLAG_Z] = (S == '0);
    ZCNVFlags[FLAG_C] = c_flag;
    ZCNVFlags[FLAG_N] = S[XLEN-1];
    ZCNVFlags[FLAG_V] = v_flag;
  end

endmodule

// File: rtl/pipeline_reg.sv
// Plain D register with async active-low clear; loads every cycle.
module pipeline_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // next value is simply the input
  always_comb begin
    q_d = d;
  end

  // state register, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile.sv
// 32x32 register file, x0 hardwired to zero, two async read ports with
// write-first bypass so a WB write is seen by ID in the same cycle.
module regfile
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd_addr0,
  input  logic [4:0]      rd_addr1,
  output logic [XLEN-1:0] rd_dout0,
  output logic [XLEN-1:0] rd_dout1,
  input  logic [4:0]      wr_addr0,
  input  logic [XLEN-1:0] wr_din0,
  input  logic            we0
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_ok;

  assign wr_ok = we0 && (wr_addr0 != 5'd0);

  // next array contents: one entry updated on a valid write, x0 pinned to 0
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr0] = wr_din0;
    regs_d[0] = '0;
  end

  // array storage; reset clears every entry and drops any write on that edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // read ports: x0 -> 0, same-cycle write -> bypass, else array
  always_comb begin
    if (rd_addr0 == 5'd0)                rd_dout0 = '0;
    else if (wr_ok && wr_addr0 == rd_addr0) rd_dout0 = wr_din0;
    else                                 rd_dout0 = regs_q[rd_addr0];

    if (rd_addr1 == 5'd0)                rd_dout1 = '0;
    else if (wr_ok && wr_addr1_match(rd_addr1)) rd_dout1 = wr_din0;
    else                                 rd_dout1 = regs_q[rd_addr1];
  end

  function automatic logic wr_addr1_match(input logic [4:0] ra);
    return wr_addr0 == ra;
  endfunction

endmodule

// File: rtl/rv32_exec_units.sv
// ID/EX slice: register file, ID/EX operand registers and the EX function unit.
module rv32_exec_units
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd_addr0,
  input  logic [4:0]      rd_addr1,
  output logic [XLEN-1:0] rd_dout0,
  output logic [XLEN-1:0] rd_dout1,
  output logic [XLEN-1:0] rs1_ex,
  output logic [XLEN-1:0] rs2_ex,
  input  logic [4:0]      wr_addr0,
  input  logic [XLEN-1:0] wr_din0,
  input  logic            we0,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      FS,
  output logic [XLEN-1:0] S,
  output logic [3:0]      ZCNVFlags
);

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_dout0 (rd_dout0),
    .rd_dout1 (rd_dout1),
    .wr_addr0 (wr_addr0),
    .wr_din0  (wr_din0),
    .we0      (we0)
  );

  pipeline_reg #(.WIDTH(XLEN)) u_rs1_ex (
    .clk (clk),
    .rst (rst),
    .d   (rd_dout0),
    .q   (rs1_ex)
  );

  pipeline_reg #(.WIDTH(XLEN)) u_rs2_ex (
    .clk (clk),
    .rst (rst),
    .d   (rd_dout1),
    .q   (rs2_ex)
  );

  FunctionUnit u_fu (
    .A         (A),
    .B         (B),
    .FS        (FS),
    .S         (S),
    .ZCNVFlags (ZCNVFlags)
  );

endmodule

// File: tb/tb_rv32_exec_units.sv
module tb_rv32_exec_units;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr0, rd_addr1, wr_addr0;
  logic [31:0] rd_dout0, rd_dout1, rs1_ex, rs2_ex, wr_din0;
  logic        we0;
  logic [31:0] A, B, S;
  logic [3:0]  FS, ZCNVFlags;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32];
  logic [31:0] exp_rs1_ex, exp_rs2_ex;

  rv32_exec_units dut (
    .clk(clk), .rst(rst),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_dout0(rd_dout0), .rd_dout1(rd_dout1),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .wr_addr0(wr_addr0), .wr_din0(wr_din0), .we0(we0),
    .A(A), .B(B), .FS(FS), .S(S), .ZCNVFlags(ZCNVFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // reference register-file read: x0 zero, pending write seen immediately
  function automatic logic [31:0] model_read(input logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (we0 && wr_addr0 != 0 && wr_addr0 == ra) return wr_din0;
    return mem[ra];
  endfunction

  // one clock: capture expected ID/EX values, then commit the write to the model
  task automatic tick();
    logic [31:0] e1, e2;
    e1 = model_read(rd_addr0);
    e2 = model_read(rd_addr1);
    @(posedge clk);
    if (rst) begin
      exp_rs1_ex = e1;
      exp_rs2_ex = e2;
      if (we0 && wr_addr0 != 0) mem[wr_addr0] = wr_din0;
    end
    #1;
  endtask

  // reference ALU from the arithmetic definitions: returns {flags, result}
  function automatic logic [35:0] ref_alu(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic [4:0]  sh;
    logic        c, v;
    longint      sa, sb, sr;
    sh = b[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0; v = 0; s = 0;
    case (fs[3:1])
      3'b000: begin
        if (fs[0] == 1'b0) begin
          s  = a + b;
          c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
          sr = sa + sb;
        end else begin
          s  = a - b;
          c  = (a >= b);
          sr = sa - sb;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b001: s = a << sh;
      3'b010: s = (sa < sb) ? 32'd1 : 32'd0;
      3'b011: s = (a < b) ? 32'd1 : 32'd0;
      3'b100: s = a ^ b;
      3'b101: begin
        if (fs[0]) s = 32'(sa / (64'sd1 << sh) - ((sa < 0 && (sa % (64'sd1 << sh)) != 0) ? 1 : 0));
        else       s = a / (32'd1 << sh);
      end
      3'b110: s = a | b;
      default: s = a & b;
    endcase
    return {(s == 0), c, s[31], v, s};
  endfunction

  typedef struct {
    string       name;
    logic [3:0]  fs;
    logic [31:0] a, b, s;
    logic [3:0]  flags;
  } alu_vec_t;

  alu_vec_t vecs[$];

  initial begin
    logic [35:0] r;

    vecs.push_back('{"add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0011});
    vecs.push_back('{"sub_eq",    4'b0001, 32'd5,        32'd5,        32'h0,        4'b1100});
    vecs.push_back('{"sub_neg",   4'b0001, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0010});
    vecs.push_back('{"add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1100});
    vecs.push_back('{"sub_ovf",   4'b0001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0101});
    vecs.push_back('{"srl",       4'b1010, 32'h80000000, 32'd4,        32'h08000000, 4'b0000});
    vecs.push_back('{"sra",       4'b1011, 32'h80000000, 32'd4,        32'hF8000000, 4'b0010});
    vecs.push_back('{"sll_b33",   4'b0010, 32'h1,        32'd33,       32'h2,        4'b0000});
    vecs.push_back('{"sll_alias", 4'b0011, 32'h1,        32'd33,       32'h2,        4'b0000});
    vecs.push_back('{"slt",       4'b0100, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000});
    vecs.push_back('{"slt_alias", 4'b0101, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000});
    vecs.push_back('{"sltu",      4'b0110, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1000});
    vecs.push_back('{"sltu_alias",4'b0111, 32'h1,        32'hFFFFFFFF, 32'h1,        4'b0000});
    vecs.push_back('{"and",       4'b1110, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F, 4'b0000});
    vecs.push_back('{"or",        4'b1100, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0010});
    vecs.push_back('{"xor",       4'b1000, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b0010});
    vecs.push_back('{"xor_alias", 4'b1001, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b0010});

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    exp_rs1_ex = 0; exp_rs2_ex = 0;
    rst = 1'b0; we0 = 0; wr_addr0 = 0; wr_din0 = 0;
    rd_addr0 = 0; rd_addr1 = 0; A = 0; B = 0; FS = 0;

    // reset and read-back of every index
    #2;
    check("rs1_ex_in_reset", rs1_ex, 32'h0);
    check("rs2_ex_in_reset", rs2_ex, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd0_x%0d", i), rd_dout0, 32'h0);
      check($sformatf("reset_rd1_x%0d", 31 - i), rd_dout1, 32'h0);
    end
    check("rs1_ex_after_reset", rs1_ex, 32'h0);

    // write x5, attempt x0
    @(negedge clk);
    we0 = 1; wr_addr0 = 5; wr_din0 = 32'hDEADBEEF;
    tick();
    @(negedge clk);
    wr_addr0 = 0; wr_din0 = 32'h12345678;
    tick();
    @(negedge clk);
    we0 = 0; rd_addr0 = 5; rd_addr1 = 0;
    #1;
    check("x5_read", rd_dout0, 32'hDEADBEEF);
    check("x0_read", rd_dout1, 32'h0);
    tick();
    check("rs1_ex_x5", rs1_ex, 32'hDEADBEEF);
    check("rs2_ex_x0", rs2_ex, 32'h0);

    // same-cycle write/read bypass, then from the array next cycle
    @(negedge clk);
    we0 = 1; wr_addr0 = 7; wr_din0 = 32'hA5A5A5A5; rd_addr1 = 7;
    #1;
    check("bypass_rd1", rd_dout1, 32'hA5A5A5A5);
    tick();
    check("bypass_rs2_ex", rs2_ex, 32'hA5A5A5A5);
    @(negedge clk);
    we0 = 0;
    #1;
    check("x7_array", rd_dout1, 32'hA5A5A5A5);

    // ALU vectors
    for (int i = 0; i < vecs.size(); i++) begin
      FS = vecs[i].fs; A = vecs[i].a; B = vecs[i].b;
      #1;
      check({vecs[i].name, "_S"}, S, vecs[i].s);
      check({vecs[i].name, "_flags"}, {28'h0, ZCNVFlags}, {28'h0, vecs[i].flags});
    end

    // randomized ALU against the reference
    for (int i = 0; i < 400; i++) begin
      FS = 4'($urandom_range(0, 15));
      A  = $urandom;
      B  = (i % 4 == 0) ? A : $urandom;
      if (i % 7 == 0) B = 32'($urandom_range(0, 40));
      #1;
      r = ref_alu(FS, A, B);
      check($sformatf("rand_alu_S fs=%0h a=%08h b=%08h", FS, A, B), S, r[31:0]);
      check($sformatf("rand_alu_flags fs=%0h a=%08h b=%08h", FS, A, B), {28'h0, ZCNVFlags}, {28'h0, r[35:32]});
    end

    // randomized register-file traffic against the array model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      we0      = ($urandom_range(0, 3) != 0);
      wr_addr0 = 5'($urandom_range(0, 7));
      wr_din0  = $urandom;
      rd_addr0 = 5'($urandom_range(0, 7));
      rd_addr1 = (i % 5 == 0) ? wr_addr0 : 5'($urandom_range(0, 7));
      #1;
      check("rand_rd0", rd_dout0, model_read(rd_addr0));
      check("rand_rd1", rd_dout1, model_read(rd_addr1));
      tick();
      check("rand_rs1_ex", rs1_ex, exp_rs1_ex);
      check("rand_rs2_ex", rs2_ex, exp_rs2_ex);
    end

    // reset in mid-write: pending write dropped, state cleared at once
    @(negedge clk);
    we0 = 1; wr_addr0 = 9; wr_din0 = 32'h55AA55AA; rd_addr0 = 9; rd_addr1 = 5;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_rs1_ex", rs1_ex, 32'h0);
    check("midrst_rd1", rd_dout1, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    @(negedge clk);
    we0 = 0; rst = 1'b1;
    #1;
    check("midrst_x9_dropped", rd_dout0, 32'h0);
    check("midrst_x5_cleared", rd_dout1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32_exec_units.md
# rv32_exec_units

Register-file, ALU and pipeline-register slice of the 5-stage RV32I core datapath. The 32×32 register file feeds ID-stage operands. Two ID/EX pipeline registers hold them for EX. A combinational function unit produces the EX result and ZCNV branch flags. Operand muxing, memory and control stay in the enclosing datapath.

## Interface
- `WIDTH`, default 32: width of each `pipeline_reg` instance. The wrapper uses 32.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `rd_addr0`, input, 5: rs1 index (ID stage).
- `rd_addr1`, input, 5: rs2 index (ID stage).
- `rd_dout0`, output, 32: rs1 data, combinational.
- `rd_dout1`, output, 32: rs2 data, combinational.
- `rs1_ex`, output, 32: `rd_dout0` registered one cycle (ID/EX).
- `rs2_ex`, output, 32: `rd_dout1` registered one cycle (ID/EX).
- `wr_addr0`, input, 5: write index (WB stage).
- `wr_din0`, input, 32: write data.
- `we0`, input, 1: write enable.
- `A`, input, 32: ALU operand A.
- `B`, input, 32: ALU operand B.
- `FS`, input, 4: function select, `{funct3, funct7[5]}`.
- `S`, output, 32: ALU result, combinational.
- `ZCNVFlags`, output, 4: bit3 = Z, bit2 = C, bit1 = N, bit0 = V.

## Operation
**Register file**
- 32 × 32-bit registers.
- x0 always reads 0; writes to x0 are discarded.
- Write: on the rising edge, if `we0` is high and `wr_addr0` ≠ 0, then `reg[wr_addr0] <= wr_din0`.
- Reads are asynchronous with write-first bypass. If `we0` is high, `wr_addr0` ≠ 0 and `wr_addr0` equals the read address, the port returns `wr_din0`.

**FunctionUnit** (purely combinational; FS encoding)
- 0000 ADD, 0001 SUB.
- 0010/0011 SLL by B[4:0].
- 0100/0101 SLT (signed): S = 1 if A < B, else 0.
- 0110/0111 SLTU (unsigned compare).
- 1000/1001 XOR.
- 1010 SRL by B[4:0]; 1011 SRA by B[4:0].
- 1100/1101 OR; 1110/1111 AND.

**Flags**
- Z = (S == 0); N = S[31].
- ADD: C = carry out of bit 31; V = signed overflow.
- SUB: computed as A + ~B + 1. C = carry out (1 means no borrow, i.e. A ≥ B unsigned). V = signed overflow.
- All other operations: C = 0, V = 0.

**pipeline_reg**
- Q <= D every rising edge; no enable.

## Timing
- Reset (`rst` low, asynchronous): all 31 architectural registers, `rs1_ex` and `rs2_ex` go to 0 immediately. They hold 0 until the first rising edge after `rst` deasserts.
- `rd_dout*`, `S` and `ZCNVFlags` are combinational; 0 cycles of latency.
- `rs*_ex` have 1 cycle of latency from `rd_addr*`.
- A write issued in cycle N is visible on `rd_dout*` in the same cycle N via bypass, and from the array in N+1.
- Writing and reading the same register in one cycle returns the new value. This is how the WB→ID hazard is resolved.
- Reset asserted mid-operation discards any pending write on that edge.

## Structure
- Sub-modules: `regfile`, `FunctionUnit`, `pipeline_reg` (parameter `WIDTH`). The wrapper instantiates one of each of the first two and two `pipeline_reg`.
- Shared package `rv32_pkg`:
  - FS code constants: `FS_ADD`, `FS_SUB`, `FS_SLL`, `FS_SLT`, `FS_SLTU`, `FS_XOR`, `FS_SRL`, `FS_SRA`, `FS_OR`, `FS_AND`.
  - Flag bit indices: `FLAG_Z` = 3, `FLAG_C` = 2, `FLAG_N` = 1, `FLAG_V` = 0.
  - `XLEN` = 32, `NREG` = 32.

## Test plan
- Reset/read: pulse `rst` low, then read all 32 indices → every value is 0, and `rs1_ex`/`rs2_ex` are 0.
- Write/x0: write x5 = 0xDEADBEEF and x0 = 0x12345678 → in the next cycle x5 reads 0xDEADBEEF, x0 reads 0, and `rs1_ex` shows 0xDEADBEEF one cycle after `rd_addr0` = 5.
- Bypass: `we0` = 1, `wr_addr0` = 7, `wr_din0` = 0xA5A5A5A5, `rd_addr1` = 7 in the same cycle → `rd_dout1` = 0xA5A5A5A5 before the edge.
- ADD/SUB flags:
  - 0x7FFFFFFF + 1 → S = 0x80000000, flags N = 1, V = 1, C = 0, Z = 0.
  - 5 − 5 → S = 0, flags Z = 1, C = 1.
  - 3 − 5 → S = 0xFFFFFFFE, flags N = 1, C = 0.
- Shifts: A = 0x80000000, B = 4.
  - SRL → 0x08000000.
  - SRA → 0xF8000000.
  - SLL, A = 1, B = 33 → 2 (only B[4:0] used).
- Compares: A = 0xFFFFFFFF, B = 1.
  - SLT → 1.
  - SLTU → 0.
  - AND/OR/XOR with B = 0x0F0F0F0F → 0x0F0F0F0F / 0xFFFFFFFF / 0xF0F0F0F0.
